// File: rtl/sim_halt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sim_halt_ctrl
// Brief    : Simulation run controller. Watches per-channel commit, halt and
//            errcode streams and decides when and why a run ends. The end
//            cause is HALT, TIMEOUT, ERROR (after a drain window) or DEADLOCK
//            (watchdog). It also keeps cycle and commit statistics.
// Revision : 1.0 - initial release
// ============================================================================
module sim_halt_ctrl #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned ERR_W        = 16,
    parameter int unsigned DRAIN_CYCLES = 5,
    parameter int unsigned WDOG_CYCLES  = 10000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [CNT_W-1:0]        timeout_limit,
    input  logic [NUM_CH-1:0]       commit,
    input  logic [NUM_CH-1:0]       halt,
    input  logic [NUM_CH*ERR_W-1:0] errcode,
    output logic                    running,
    output logic                    finish,
    output logic                    finish_pulse,
    output logic [2:0]              cause,
    output logic [2:0]              err_ch,
    output logic [ERR_W-1:0]        err_val,
    output logic [CNT_W-1:0]        cycle_count,
    output logic [CNT_W-1:0]        commit_count
);

    localparam logic [2:0] CAUSE_NONE     = 3'd0;
    localparam logic [2:0] CAUSE_HALT     = 3'd1;
    localparam logic [2:0] CAUSE_TIMEOUT  = 3'd2;
    localparam logic [2:0] CAUSE_ERROR    = 3'd3;
    localparam logic [2:0] CAUSE_DEADLOCK = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(WDOG_CYCLES);

    // Drain counter counts down from DRAIN_CYCLES-1 to 0 inside DRAIN.
    localparam int unsigned      DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = {{(DRAIN_W-1){1'b0}}, 1'b1};
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_W'(DRAIN_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [DRAIN_W-1:0] drain_q;
    logic [CNT_W-1:0]   idle_q;
    logic [CNT_W-1:0]   cycle_q;
    logic [CNT_W-1:0]   commit_q;
    logic               running_q;
    logic               finish_q;
    logic               pulse_q;
    logic [2:0]         cause_q;
    logic [2:0]         err_ch_q;
    logic [ERR_W-1:0]   err_val_q;

    logic               err_any_w;
    logic [2:0]         err_ch_w;
    logic [ERR_W-1:0]   err_val_w;
    logic [3:0]         pop_w;
    logic [CNT_W+3:0]   commit_sum_w;
    logic [CNT_W-1:0]   commit_d;
    logic [CNT_W-1:0]   cycle_d;
    logic [CNT_W-1:0]   idle_d;
    logic               timeout_w;
    logic               deadlock_w;

    // Error scan: walk from the top channel down so the lowest index wins.
    always_comb begin
        err_any_w = 1'b0;
        err_ch_w  = 3'd0;
        err_val_w = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (|errcode[i*ERR_W +: ERR_W]) begin
                err_any_w = 1'b1;
                err_ch_w  = 3'(i);
                err_val_w = errcode[i*ERR_W +: ERR_W];
            end
        end
    end

    // Count how many channels retired an instruction this cycle.
    always_comb begin
        pop_w = 4'd0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            pop_w = pop_w + {3'b000, commit[i]};
        end
    end

    // Saturating next values for the counters and the end-condition detectors.
    always_comb begin
        commit_sum_w = {4'b0000, commit_q} + {{CNT_W{1'b0}}, pop_w};
        commit_d     = (|commit_sum_w[CNT_W+3:CNT_W]) ? CNT_MAX : commit_sum_w[CNT_W-1:0];
        cycle_d      = (cycle_q == CNT_MAX) ? CNT_MAX : (cycle_q + CNT_ONE);
        idle_d       = (|commit) ? '0 : (idle_q + CNT_ONE);
        // cycle_q+1 wraps to 0 when saturated, so a nonzero limit cannot match.
        timeout_w    = (timeout_limit != '0) && ((cycle_q + CNT_ONE) == timeout_limit);
        deadlock_w   = (WDOG_CYCLES != 0) && (idle_d == WDOG_LIM);
    end

    // Run-control FSM with registered status outputs and statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            drain_q   <= '0;
            idle_q    <= '0;
            cycle_q   <= '0;
            commit_q  <= '0;
            running_q <= 1'b0;
            finish_q  <= 1'b0;
            pulse_q   <= 1'b0;
            cause_q   <= CAUSE_NONE;
            err_ch_q  <= 3'd0;
            err_val_q <= '0;
        end else begin
            pulse_q <= 1'b0;
            if (state_q == ST_RUN || state_q == ST_DRAIN) begin
                cycle_q  <= cycle_d;
                commit_q <= commit_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                        idle_q    <= '0;
                    end
                end
                ST_RUN: begin
                    idle_q <= idle_d;
                    if (err_any_w) begin
                        cause_q   <= CAUSE_ERROR;
                        err_ch_q  <= err_ch_w;
                        err_val_q <= err_val_w;
                        if (DRAIN_CYCLES == 0) begin
                            state_q   <= ST_DONE;
                            running_q <= 1'b0;
                            finish_q  <= 1'b1;
                            pulse_q   <= 1'b1;
                        end else begin
                            state_q <= ST_DRAIN;
                            drain_q <= DRAIN_LOAD;
                        end
                    end else if (|halt) begin
                        cause_q   <= CAUSE_HALT;
                        state_q   <= ST_DONE;
                        running_q <= 1'b0;
                        finish_q  <= 1'b1;
                        pulse_q   <= 1'b1;
                    end else if (deadlock_w) begin
                        cause_q   <= CAUSE_DEADLOCK;
                        state_q   <= ST_DONE;
                        running_q <= 1'b0;
                        finish_q  <= 1'b1;
                        pulse_q   <= 1'b1;
                    end else if (timeout_w) begin
                        cause_q   <= CAUSE_TIMEOUT;
                        state_q   <= ST_DONE;
                        running_q <= 1'b0;
                        finish_q  <= 1'b1;
                        pulse_q   <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Halt, timeout and deadlock are deliberately ignored here.
                    if (drain_q == '0) begin
                        state_q   <= ST_DONE;
                        running_q <= 1'b0;
                        finish_q  <= 1'b1;
                        pulse_q   <= 1'b1;
                    end else begin
                        drain_q <= drain_q - DRAIN_ONE;
                    end
                end
                default: begin
                    // DONE holds until reset.
                end
            endcase
        end
    end

    assign running      = running_q;
    assign finish       = finish_q;
    assign finish_pulse = pulse_q;
    assign cause        = cause_q;
    assign err_ch       = err_ch_q;
    assign err_val      = err_val_q;
    assign cycle_count  = cycle_q;
    assign commit_count = commit_q;

endmodule
`default_nettype wire

// File: tb/tb_sim_halt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_halt_ctrl
// Brief    : Directed self-checking bench for sim_halt_ctrl. Per-cycle table
//            vectors plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_halt_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] tl = '0;
    logic [1:0]  commit = '0;
    logic [1:0]  halt = '0;
    logic [31:0] errcode = '0;

    logic        running;
    logic        finish;
    logic        finish_pulse;
    logic [2:0]  cause;
    logic [2:0]  err_ch;
    logic [15:0] err_val;
    logic [31:0] cycle_count;
    logic [31:0] commit_count;

    int errors = 0;
    int checks = 0;

    sim_halt_ctrl #(
        .NUM_CH       (2),
        .CNT_W        (32),
        .ERR_W        (16),
        .DRAIN_CYCLES (5),
        .WDOG_CYCLES  (50)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .timeout_limit (tl),
        .commit        (commit),
        .halt          (halt),
        .errcode       (errcode),
        .running       (running),
        .finish        (finish),
        .finish_pulse  (finish_pulse),
        .cause         (cause),
        .err_ch        (err_ch),
        .err_val       (err_val),
        .cycle_count   (cycle_count),
        .commit_count  (commit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        en;
        logic [31:0] t;
        logic [1:0]  cm;
        logic [1:0]  ht;
        logic [31:0] ec;
        logic [88:0] exp;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl [NV];

    function automatic vec_t v(input logic r, input logic en, input logic [31:0] t,
                               input logic [1:0] cm, input logic [1:0] ht, input logic [31:0] ec,
                               input logic run, input logic fin, input logic pls,
                               input logic [2:0] ca, input logic [2:0] ech, input logic [15:0] ev,
                               input logic [31:0] cy, input logic [31:0] cc);
        vec_t x;
        x.r   = r;
        x.en  = en;
        x.t   = t;
        x.cm  = cm;
        x.ht  = ht;
        x.ec  = ec;
        x.exp = {run, fin, pls, ca, ech, ev, cy, cc};
        return x;
    endfunction

    function automatic logic [88:0] dut_pack();
        return {running, finish, finish_pulse, cause, err_ch, err_val, cycle_count, commit_count};
    endfunction

    task automatic check(input string name, input logic [88:0] act, input logic [88:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; enable = 1'b0; tl = '0; commit = '0; halt = '0; errcode = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic start_run();
        @(negedge clk);
        enable = 1'b1; commit = '0; halt = '0; errcode = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [1:0] cm, input logic [1:0] ht, input logic [31:0] ec);
        @(negedge clk);
        enable = 1'b0; commit = cm; halt = ht; errcode = ec;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        int at;
        int pulses;
        logic dropped;

        // r  en tl     cm     ht     ec             run  fin  pls  cause ech  eval    cyc     cmc
        tbl[0]  = v(1'b0,1'b0,32'd0,2'b00,2'b00,32'h0,          1'b0,1'b0,1'b0,3'd0,3'd0,16'h0,32'd0,32'd0);
        tbl[1]  = v(1'b1,1'b0,32'd0,2'b11,2'b00,32'h0,          1'b0,1'b0,1'b0,3'd0,3'd0,16'h0,32'd0,32'd0);
        tbl[2]  = v(1'b1,1'b1,32'd0,2'b11,2'b00,32'h0,          1'b1,1'b0,1'b0,3'd0,3'd0,16'h0,32'd0,32'd0);
        tbl[3]  = v(1'b1,1'b0,32'd0,2'b01,2'b00,32'h0,          1'b1,1'b0,1'b0,3'd0,3'd0,16'h0,32'd1,32'd1);
        tbl[4]  = v(1'b1,1'b0,32'd0,2'b11,2'b00,32'h0,          1'b1,1'b0,1'b0,3'd0,3'd0,16'h0,32'd2,32'd3);
        tbl[5]  = v(1'b1,1'b0,32'd0,2'b10,2'b10,32'h0,          1'b0,1'b1,1'b1,3'd1,3'd0,16'h0,32'd3,32'd4);
        tbl[6]  = v(1'b1,1'b0,32'd0,2'b11,2'b00,32'h0,          1'b0,1'b1,1'b0,3'd1,3'd0,16'h0,32'd3,32'd4);
        tbl[7]  = v(1'b1,1'b0,32'd0,2'b00,2'b00,32'h0000_0009,  1'b0,1'b1,1'b0,3'd1,3'd0,16'h0,32'd3,32'd4);
        tbl[8]  = v(1'b0,1'b0,32'd0,2'b00,2'b00,32'h0,          1'b0,1'b0,1'b0,3'd0,3'd0,16'h0,32'd0,32'd0);
        tbl[9]  = v(1'b1,1'b1,32'd0,2'b00,2'b00,32'h0,          1'b1,1'b0,1'b0,3'd0,3'd0,16'h0,32'd0,32'd0);
        tbl[10] = v(1'b1,1'b0,32'd0,2'b00,2'b01,32'h0005_0000,  1'b1,1'b0,1'b0,3'd3,3'd1,16'h5,32'd1,32'd0);
        tbl[11] = v(1'b1,1'b0,32'd0,2'b01,2'b11,32'h0,          1'b1,1'b0,1'b0,3'd3,3'd1,16'h5,32'd2,32'd1);
        tbl[12] = v(1'b1,1'b0,32'd0,2'b01,2'b11,32'h0,          1'b1,1'b0,1'b0,3'd3,3'd1,16'h5,32'd3,32'd2);
        tbl[13] = v(1'b1,1'b0,32'd0,2'b01,2'b00,32'h0,          1'b1,1'b0,1'b0,3'd3,3'd1,16'h5,32'd4,32'd3);
        tbl[14] = v(1'b1,1'b0,32'd0,2'b01,2'b00,32'h0000_0001,  1'b1,1'b0,1'b0,3'd3,3'd1,16'h5,32'd5,32'd4);
        tbl[15] = v(1'b1,1'b0,32'd0,2'b00,2'b00,32'h0,          1'b0,1'b1,1'b1,3'd3,3'd1,16'h5,32'd6,32'd4);
        tbl[16] = v(1'b1,1'b0,32'd0,2'b11,2'b00,32'h0,          1'b0,1'b1,1'b0,3'd3,3'd1,16'h5,32'd6,32'd4);
        tbl[17] = v(1'b0,1'b0,32'd0,2'b00,2'b00,32'h0,          1'b0,1'b0,1'b0,3'd0,3'd0,16'h0,32'd0,32'd0);
        tbl[18] = v(1'b1,1'b1,32'd2,2'b00,2'b00,32'h0,          1'b1,1'b0,1'b0,3'd0,3'd0,16'h0,32'd0,32'd0);
        tbl[19] = v(1'b1,1'b0,32'd2,2'b01,2'b00,32'h0,          1'b1,1'b0,1'b0,3'd0,3'd0,16'h0,32'd1,32'd1);
        tbl[20] = v(1'b1,1'b0,32'd2,2'b01,2'b01,32'h0,          1'b0,1'b1,1'b1,3'd1,3'd0,16'h0,32'd2,32'd2);
        tbl[21] = v(1'b0,1'b0,32'd0,2'b00,2'b00,32'h0,          1'b0,1'b0,1'b0,3'd0,3'd0,16'h0,32'd0,32'd0);
        tbl[22] = v(1'b1,1'b1,32'd3,2'b00,2'b00,32'h0,          1'b1,1'b0,1'b0,3'd0,3'd0,16'h0,32'd0,32'd0);
        tbl[23] = v(1'b1,1'b0,32'd3,2'b00,2'b00,32'h0,          1'b1,1'b0,1'b0,3'd0,3'd0,16'h0,32'd1,32'd0);
        tbl[24] = v(1'b1,1'b0,32'd3,2'b00,2'b00,32'h0,          1'b1,1'b0,1'b0,3'd0,3'd0,16'h0,32'd2,32'd0);
        tbl[25] = v(1'b1,1'b0,32'd3,2'b00,2'b00,32'h0,          1'b0,1'b1,1'b1,3'd2,3'd0,16'h0,32'd3,32'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = tbl[i].r; enable = tbl[i].en; tl = tbl[i].t;
            commit = tbl[i].cm; halt = tbl[i].ht; errcode = tbl[i].ec;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), dut_pack(), tbl[i].exp);
        end

        // Halt on channel 1 in RUN cycle 20 with both channels committing.
        do_reset();
        start_run();
        for (int k = 1; k <= 19; k++) step(2'b11, 2'b00, 32'h0);
        check("halt_not_early", 89'(finish), 89'(0));
        step(2'b11, 2'b10, 32'h0);
        check("halt_status", 89'({finish, finish_pulse, cause}), 89'({1'b1, 1'b1, 3'd1}));
        check("halt_cycles", 89'(cycle_count), 89'(20));
        check("halt_commits", 89'(commit_count), 89'(40));

        // Timeout after exactly 100 RUN cycles.
        do_reset();
        tl = 32'd100;
        start_run();
        at = 0;
        for (int k = 1; k <= 150; k++) begin
            step(2'b11, 2'b00, 32'h0);
            if (finish) begin
                at = k;
                break;
            end
        end
        check("timeout_edge", 89'(at), 89'(100));
        check("timeout_cause", 89'(cause), 89'(2));
        check("timeout_cycles", 89'(cycle_count), 89'(100));

        // Two channels error together, halt follows in DRAIN.
        do_reset();
        start_run();
        step(2'b11, 2'b00, 32'h0);
        step(2'b11, 2'b00, 32'h0);
        step(2'b00, 2'b00, 32'h0007_0003);
        check("err_latch", 89'({running, finish, cause, err_ch, err_val}),
              89'({1'b1, 1'b0, 3'd3, 3'd0, 16'h0003}));
        at = 0;
        for (int k = 1; k <= 20; k++) begin
            step(2'b00, (k == 1) ? 2'b11 : 2'b00, 32'h0);
            if (finish) begin
                at = k;
                break;
            end
        end
        check("drain_len", 89'(at), 89'(5));
        check("drain_done", 89'({cause, err_ch, err_val}), 89'({3'd3, 3'd0, 16'h0003}));
        check("drain_counts", 89'({cycle_count, commit_count}), 89'({32'd8, 32'd4}));

        // Watchdog: commits stop after cycle 10, deadlock 50 cycles later.
        do_reset();
        start_run();
        for (int k = 1; k <= 10; k++) step(2'b01, 2'b00, 32'h0);
        at = 0;
        for (int k = 11; k <= 200; k++) begin
            step(2'b00, 2'b00, 32'h0);
            if (finish) begin
                at = k;
                break;
            end
        end
        check("wdog_edge", 89'(at), 89'(60));
        check("wdog_status", 89'({cause, cycle_count, commit_count}), 89'({3'd4, 32'd60, 32'd10}));

        // Asynchronous reset in the middle of DRAIN, then a clean halt run.
        do_reset();
        start_run();
        step(2'b01, 2'b00, 32'h0);
        step(2'b00, 2'b00, 32'h0000_0004);
        step(2'b00, 2'b00, 32'h0);
        step(2'b00, 2'b00, 32'h0);
        check("pre_reset_drain", 89'({running, cause, err_val}), 89'({1'b1, 3'd3, 16'h0004}));
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", dut_pack(), 89'(0));
        @(negedge clk);
        rst = 1'b1;
        start_run();
        step(2'b00, 2'b01, 32'h0);
        check("rerun_halt", 89'({finish, cause, err_ch, err_val}), 89'({1'b1, 3'd1, 3'd0, 16'h0}));

        // Halt and error in the same cycle: error wins, exactly one pulse.
        do_reset();
        start_run();
        step(2'b01, 2'b01, 32'h0000_0002);
        check("err_over_halt", 89'({running, cause}), 89'({1'b1, 3'd3}));
        pulses = 0;
        dropped = 1'b0;
        at = 0;
        for (int k = 1; k <= 20; k++) begin
            step(2'b11, 2'b11, 32'h0);
            if (finish_pulse) pulses++;
            if (finish) at = 1;
            else if (at != 0) dropped = 1'b1;
        end
        check("pulse_once", 89'(pulses), 89'(1));
        check("finish_held", 89'({finish, dropped, cause}), 89'({1'b1, 1'b0, 3'd3}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sim_halt_ctrl.md
SIM_HALT_CTRL -- requirements
Module: sim_halt_ctrl

Interface
REQ-001 SHALL provide parameter NUM_CH, default 2, meaning number of commit/monitor channels (1..8).
REQ-002 SHALL provide parameter CNT_W, default 32, meaning width of cycle, timeout and commit counters.
REQ-003 SHALL provide parameter ERR_W, default 16, meaning width of each channel errcode.
REQ-004 SHALL provide parameter DRAIN_CYCLES, default 5, meaning cycles between error detection and finish (0 = immediate).
REQ-005 SHALL provide parameter WDOG_CYCLES, default 10000, meaning consecutive commit-free RUN cycles that declare deadlock (0 = disabled).
REQ-006 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-007 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports: enable  in  1  level; starts monitoring when high in IDLE.
REQ-009 SHALL have ports: timeout_limit  in  CNT_W  RUN-cycle budget; 0 disables timeout; sampled every cycle.
REQ-010 SHALL have ports: commit  in  NUM_CH  per-channel instruction-retire strobe.
REQ-011 SHALL have ports: halt  in  NUM_CH  per-channel halt request.
REQ-012 SHALL have ports: errcode  in  NUM_CH*ERR_W  packed errcodes, channel i at bits [i*ERR_W +: ERR_W]; nonzero = error.
REQ-013 SHALL have ports: running  out  1  high in RUN and DRAIN.
REQ-014 SHALL have ports: finish  out  1  level, high in DONE until reset.
REQ-015 SHALL have ports: finish_pulse  out  1  one-cycle pulse on DONE entry.
REQ-016 SHALL have ports: cause  out  3  0 NONE, 1 HALT, 2 TIMEOUT, 3 ERROR, 4 DEADLOCK.
REQ-017 SHALL have ports: err_ch  out  3  channel of latched error; err_val  out  ERR_W  its errcode.
REQ-018 SHALL have ports: cycle_count  out  CNT_W  RUN+DRAIN cycles elapsed; commit_count  out  CNT_W  total commits.

Function
REQ-019 SHALL implement FSM IDLE -> RUN (enable high) -> DONE (halt/timeout/deadlock) or RUN -> DRAIN (error) -> DONE; DONE is terminal until reset.
REQ-020 SHALL register all outputs; a condition sampled at edge E is reflected in state/outputs immediately after E.
REQ-021 SHALL, in RUN, resolve simultaneous conditions with priority ERROR > HALT > DEADLOCK > TIMEOUT.
REQ-022 SHALL, among multiple erroring channels in one cycle, latch the lowest index into err_ch/err_val; later errors on any channel are ignored.
REQ-023 SHALL, on error sampled at edge E0, enter DRAIN and assert finish at edge E0+DRAIN_CYCLES; DRAIN_CYCLES=0 goes directly to DONE at E0.
REQ-024 SHALL ignore halt, timeout and deadlock while in DRAIN; cause remains ERROR.
REQ-025 SHALL go to DONE with cause HALT at the edge sampling any halt bit high in RUN.
REQ-026 SHALL increment cycle_count once per cycle in RUN/DRAIN, holding in IDLE/DONE and saturating at all-ones.
REQ-027 SHALL declare TIMEOUT at the edge where cycle_count+1 equals timeout_limit (nonzero), i.e. after exactly timeout_limit RUN cycles.
REQ-028 SHALL keep an idle counter cleared by any commit bit and incremented otherwise in RUN; DEADLOCK when it reaches WDOG_CYCLES.
REQ-029 SHALL add popcount(commit) to commit_count each RUN/DRAIN cycle, saturating at all-ones; commits in IDLE/DONE ignored.
REQ-030 SHALL ignore enable after leaving IDLE; deasserting it does not pause or stop monitoring.
REQ-031 SHALL treat a halt and commit on the same channel in the same cycle as both counted and halting.

Reset
REQ-032 SHALL, on rst low at any time including mid-DRAIN, asynchronously force IDLE and all outputs to 0 (cause NONE, counters 0).
REQ-033 SHALL resume normal operation at the first rising edge after rst deasserts, starting in IDLE.

Verification
REQ-034 SHALL verify: enable=1, commit every cycle, halt[1] at RUN cycle 20 -> finish at that edge, cause=1, cycle_count=20, commit_count=40 with NUM_CH=2.
REQ-035 SHALL verify: timeout_limit=100, commits continuous, no halt -> finish after 100 RUN cycles, cause=2, cycle_count=100.
REQ-036 SHALL verify: errcode ch1=0x7 and ch0=0x3 same cycle, halt next cycle -> DRAIN 5 cycles, cause=3, err_ch=0, err_val=0x3.
REQ-037 SHALL verify: WDOG_CYCLES=50, commits stop at cycle 10 -> finish 50 cycles later, cause=4.
REQ-038 SHALL verify: rst low during DRAIN cycle 2 -> all outputs 0 immediately; re-enable then halt -> cause=1, err_val=0.
REQ-039 SHALL verify: halt and errcode asserted same cycle -> cause=3, finish_pulse exactly once, finish held until reset.
